hazard_unit: RTL

Producer-side companion to the forwarding unit in the 5-stage pipeline. Tracks destination-register tags through the ID/EX, EX/MEM and MEM/WB stages and drives the `fwd_rd`/`fwd_rd2` tags (with valid qualifiers) that the forwarding unit compares against `rs`/`rt`. Also detects load-use hazards and, optionally, multi-cycle EX occupancy, and generates the stall and bubble controls for the front end.

---
 rtl/hazard_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Pipeline tag tracker and load-use/multi-cycle interlock; tags reach fwd_rd one edge after ID/EX capture, fwd_rd2 one edge later.
// stall/bubble are combinational; HAZARD_MULDIV_EN adds a MULDIV_LAT-cycle EX occupancy interlock with a sticky flush-kill flag.
module hazard_unit #(
   parameter int MULDIV_LAT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic [4:0] id_rd,
   input  logic       id_regwrite,
   input  logic       id_memread,
   input  logic       id_multicycle,
   input  logic       flush,
   output logic [4:0] fwd_rd,
   output logic       fwd_rd_vld,
   output logic [4:0] fwd_rd2,
   output logic       fwd_rd2_vld,
   output logic       stall,
   output logic       bubble
);

   typedef struct packed {
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } stage_t;

   stage_t idex_q, exmem_q, memwb_q;
   stage_t id_cap;
   logic   rs_hit, rt_hit, load_use;
   logic   busy, drain, killed;

   always_comb begin
      id_cap    = '0;
      id_cap.rd = id_rd;
      id_cap.wr = id_valid & id_regwrite & (id_rd != 5'd0);
      id_cap.ld = id_valid & id_memread;
   end

`ifdef HAZARD_MULDIV_EN
   logic [3:0] cnt_q;
   logic       kill_q;

   assign busy   = (cnt_q != 4'd0);
   assign killed = kill_q;
   // A killed instruction still sits in IF/ID once busy ends; retire it as a bubble.
   assign drain  = kill_q & ~busy;
`else
   logic unused_multicycle;
   localparam int unused_lat = MULDIV_LAT;

   assign unused_multicycle = id_multicycle;
   assign busy   = 1'b0;
   assign killed = 1'b0;
   assign drain  = 1'b0;
`endif

   assign rs_hit = (idex_q.rd == id_rs);
   assign rt_hit = (idex_q.rd == id_rt);

   always_comb begin
      load_use = id_valid & idex_q.ld & idex_q.wr & (rs_hit | (id_uses_rt & rt_hit))
               & ~flush & ~busy & ~killed;
      stall    = load_use | busy;
      bubble   = ~busy & (load_use | flush | drain);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else if (busy) begin
         exmem_q <= '0;
         memwb_q <= exmem_q;
      end else begin
         idex_q  <= bubble ? stage_t'('0) : id_cap;
         exmem_q <= idex_q;
         memwb_q <= exmem_q;
      end
   end

`ifdef HAZARD_MULDIV_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 4'd0;
         kill_q <= 1'b0;
      end else if (busy) begin
         cnt_q <= cnt_q - 4'd1;
         if (flush)
            kill_q <= 1'b1;
      end else begin
         kill_q <= 1'b0;
         cnt_q  <= (~bubble & id_valid & id_multicycle) ? 4'(MULDIV_LAT - 1) : 4'd0;
      end
   end
`endif

   assign fwd_rd      = exmem_q.rd;
   assign fwd_rd_vld  = exmem_q.wr;
   assign fwd_rd2     = memwb_q.rd;
   assign fwd_rd2_vld = memwb_q.wr;

endmodule
